// File: rtl/csc_pkg.sv
// Colour space conversion constants and types, shared by the RGB->YCbCr and
// YCbCr->RGB datapaths.
package csc_pkg;

  // BT.601 limited-range forward matrix, 8-bit fixed point (x/256)
  localparam int CoefYR  = 66;
  localparam int CoefYG  = 129;
  localparam int CoefYB  = 25;
  localparam int CoefCbR = -38;
  localparam int CoefCbG = -74;
  localparam int CoefCbB = 112;
  localparam int CoefCrR = 112;
  localparam int CoefCrG = -94;
  localparam int CoefCrB = -18;

  localparam int OffY   = 16;
  localparam int OffC   = 128;
  localparam int RoundK = 128;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] c;
    logic       c_is_cr;
    logic       sol;
    logic       eol;
  } beat_t;

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(s >> 1);
  endfunction

endpackage

// File: rtl/rgb2ycbcr_444.sv
// Two-stage pipelined RGB888 -> YCbCr 4:4:4 matrix with valid/sol/eol sideband.
module rgb2ycbcr_444
  import csc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sol,
  input  logic       in_eol,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       out_valid,
  output logic       out_sol,
  output logic       out_eol,
  output logic [7:0] y,
  output logic [7:0] cb,
  output logic [7:0] cr
);

  logic       s1_valid, s1_sol, s1_eol;
  logic [7:0] s1_r, s1_g, s1_b;
  logic [7:0] y_d, cb_d, cr_d;
  int         y_full, cb_full, cr_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sol   <= in_sol & in_valid;
      s1_eol   <= in_eol & in_valid;
      s1_r     <= r;
      s1_g     <= g;
      s1_b     <= b;
    end
  end

  // Signed 32-bit intermediates; >>> floors negative chroma sums
  always_comb begin
    y_full  = OffY + ((CoefYR * int'(s1_r) + CoefYG * int'(s1_g) + CoefYB * int'(s1_b)
                       + RoundK) >>> 8);
    cb_full = OffC + ((CoefCbR * int'(s1_r) + CoefCbG * int'(s1_g) + CoefCbB * int'(s1_b)
                       + RoundK) >>> 8);
    cr_full = OffC + ((CoefCrR * int'(s1_r) + CoefCrG * int'(s1_g) + CoefCrB * int'(s1_b)
                       + RoundK) >>> 8);
    y_d     = 8'(y_full);
    cb_d    = 8'(cb_full);
    cr_d    = 8'(cr_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      y         <= '0;
      cb        <= '0;
      cr        <= '0;
    end else begin
      out_valid <= s1_valid;
      out_sol   <= s1_sol;
      out_eol   <= s1_eol;
      y         <= y_d;
      cb        <= cb_d;
      cr        <= cr_d;
    end
  end

endmodule

// File: rtl/rgb2ycbcr_422.sv
// RGB888 -> BT.601 YCbCr 4:2:2 converter: 4:4:4 matrix followed by pair/decimation
// stage producing a {Y, C} beat per input pixel.
module rgb2ycbcr_422
  import csc_pkg::*;
#(
  parameter bit CHROMA_AVG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sol,
  input  logic       in_eol,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       out_valid,
  output logic [7:0] y_out,
  output logic [7:0] c_out,
  output logic       c_is_cr,
  output logic       out_sol,
  output logic       out_eol,
  output logic       drop_err
);

  logic       s2_valid, s2_sol, s2_eol;
  logic [7:0] s2_y, s2_cb, s2_cr;

  rgb2ycbcr_444 u_matrix (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sol    (in_sol),
    .in_eol    (in_eol),
    .r         (r),
    .g         (g),
    .b         (b),
    .out_valid (s2_valid),
    .out_sol   (s2_sol),
    .out_eol   (s2_eol),
    .y         (s2_y),
    .cb        (s2_cb),
    .cr        (s2_cr)
  );

  // phase_q = 1 means an even pixel is pending
  logic       phase_q, phase_d;
  logic [7:0] pend_y_q, pend_y_d, pend_cb_q, pend_cb_d, pend_cr_q, pend_cr_d;
  logic       pend_sol_q, pend_sol_d;
  logic       slot_valid_q, slot_valid_d;
  beat_t      slot_q, slot_d;
  logic       out_valid_q, out_valid_d;
  beat_t      out_q, out_d;
  logic       drop_q, drop_d;
  logic       is_odd;
  logic [7:0] cb_a, cr_a;

  always_comb begin
    phase_d      = phase_q;
    pend_y_d     = pend_y_q;
    pend_cb_d    = pend_cb_q;
    pend_cr_d    = pend_cr_q;
    pend_sol_d   = pend_sol_q;
    slot_valid_d = 1'b0;
    slot_d       = '0;
    drop_d       = 1'b0;
    // Default: drain the odd-beat slot scheduled last cycle (zeros when empty)
    out_valid_d  = slot_valid_q;
    out_d        = slot_q;

    is_odd = phase_q & ~s2_sol;
    cb_a   = CHROMA_AVG ? avg8(pend_cb_q, s2_cb) : pend_cb_q;
    cr_a   = CHROMA_AVG ? avg8(pend_cr_q, s2_cr) : s2_cr;

    if (s2_valid) begin
      if (is_odd) begin
        out_valid_d  = 1'b1;
        out_d        = '{y: pend_y_q, c: cb_a, c_is_cr: 1'b0, sol: pend_sol_q, eol: 1'b0};
        slot_valid_d = 1'b1;
        slot_d       = '{y: s2_y, c: cr_a, c_is_cr: 1'b1, sol: 1'b0, eol: s2_eol};
        phase_d      = 1'b0;
      end else begin
        drop_d = s2_sol & phase_q;
        if (s2_eol) begin
          // Odd-length line: lone even pixel goes out in the odd-beat slot
          slot_valid_d = 1'b1;
          slot_d       = '{y: s2_y, c: s2_cb, c_is_cr: 1'b0, sol: s2_sol, eol: 1'b1};
          phase_d      = 1'b0;
        end else begin
          phase_d    = 1'b1;
          pend_y_d   = s2_y;
          pend_cb_d  = s2_cb;
          pend_cr_d  = s2_cr;
          pend_sol_d = s2_sol;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= 1'b0;
      pend_y_q     <= '0;
      pend_cb_q    <= '0;
      pend_cr_q    <= '0;
      pend_sol_q   <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      drop_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      pend_y_q     <= pend_y_d;
      pend_cb_q    <= pend_cb_d;
      pend_cr_q    <= pend_cr_d;
      pend_sol_q   <= pend_sol_d;
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      drop_q       <= drop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y_out     = out_q.y;
  assign c_out     = out_q.c;
  assign c_is_cr   = out_q.c_is_cr;
  assign out_sol   = out_q.sol;
  assign out_eol   = out_q.eol;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_rgb2ycbcr_422.sv
// Directed bench for rgb2ycbcr_422: averaged and non-averaged instances share stimulus.
module tb_rgb2ycbcr_422;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, in_sol = 1'b0, in_eol = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;

  logic       a_valid, a_cr, a_sol, a_eol, a_drop;
  logic [7:0] a_y, a_c;
  logic       n_valid, n_cr, n_sol, n_eol, n_drop;
  logic [7:0] n_y, n_c;

  rgb2ycbcr_422 #(.CHROMA_AVG(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sol(in_sol), .in_eol(in_eol),
    .r(r), .g(g), .b(b), .out_valid(a_valid), .y_out(a_y), .c_out(a_c),
    .c_is_cr(a_cr), .out_sol(a_sol), .out_eol(a_eol), .drop_err(a_drop)
  );

  rgb2ycbcr_422 #(.CHROMA_AVG(1'b0)) dut_na (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sol(in_sol), .in_eol(in_eol),
    .r(r), .g(g), .b(b), .out_valid(n_valid), .y_out(n_y), .c_out(n_c),
    .c_is_cr(n_cr), .out_sol(n_sol), .out_eol(n_eol), .drop_err(n_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] y;
    logic [7:0] c;
    logic [7:0] c_na;
    logic       cr;
    logic       sol;
    logic       eol;
  } obs_t;

  obs_t beats[$];
  int   drops[$];

  always @(negedge clk) begin
    if (a_valid)
      beats.push_back('{cyc: cyc, y: a_y, c: a_c, c_na: n_c, cr: a_cr, sol: a_sol, eol: a_eol});
    if (a_drop) drops.push_back(cyc);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input int ecyc,
                          input logic [7:0] ey, input logic [7:0] ec, input logic [7:0] ecna,
                          input logic ecr, input logic esol, input logic eeol);
    chk({tag, ".present"}, 32'(beats.size() > idx), 1);
    if (beats.size() > idx) begin
      chk({tag, ".cycle"}, beats[idx].cyc, ecyc);
      chk({tag, ".y"}, 32'(beats[idx].y), 32'(ey));
      chk({tag, ".c_avg"}, 32'(beats[idx].c), 32'(ec));
      chk({tag, ".c_noavg"}, 32'(beats[idx].c_na), 32'(ecna));
      chk({tag, ".c_is_cr"}, 32'(beats[idx].cr), 32'(ecr));
      chk({tag, ".sol"}, 32'(beats[idx].sol), 32'(esol));
      chk({tag, ".eol"}, 32'(beats[idx].eol), 32'(eeol));
    end
  endtask

  task automatic pix(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                     input logic s, input logic e, output int n);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sol   = s;
    in_eol   = e;
    r        = rr;
    g        = gg;
    b        = bb;
    n        = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sol   = 1'b0;
      in_eol   = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_eol   = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".outputs_zero"},
        32'({a_valid, a_y, a_c, a_cr, a_sol, a_eol, a_drop, n_valid, n_c, n_drop}), 0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic [7:0] y0, y1, cb_avg, cr_avg, cb_even, cr_odd;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n0, n1, n2, n3, n4, n5, m1, m2;

    //            even pixel     odd pixel      Y0   Y1   CbA  CrA  Cb0  Cr1
    vecs[0] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
                8'd235, 8'd235, 8'd128, 8'd128, 8'd128, 8'd128};
    vecs[1] = '{8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd82, 8'd82, 8'd90, 8'd240, 8'd90, 8'd240};
    vecs[2] = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                8'd82, 8'd16, 8'd109, 8'd184, 8'd90, 8'd128};
    vecs[3] = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255,
                8'd144, 8'd41, 8'd147, 8'd72, 8'd54, 8'd110};

    do_reset("reset0");
    idle(2);

    for (int i = 0; i < 4; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      beats.delete();
      drops.delete();
      pix(vecs[i].r0, vecs[i].g0, vecs[i].b0, 1'b1, 1'b0, n0);
      pix(vecs[i].r1, vecs[i].g1, vecs[i].b1, 1'b0, 1'b1, n1);
      idle(6);
      chk({tag, ".beats"}, beats.size(), 2);
      chk({tag, ".drops"}, drops.size(), 0);
      chk_beat({tag, ".even"}, 0, n1 + 3, vecs[i].y0, vecs[i].cb_avg, vecs[i].cb_even,
               1'b0, 1'b1, 1'b0);
      chk_beat({tag, ".odd"}, 1, n1 + 4, vecs[i].y1, vecs[i].cr_avg, vecs[i].cr_odd,
               1'b1, 1'b0, 1'b1);
    end

    // Odd-length line of three black pixels, then a red pair on a new line
    beats.delete();
    drops.delete();
    pix(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, n1);
    pix(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, n2);
    pix(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, n3);
    pix(8'd255, 8'd0, 8'd0, 1'b1, 1'b0, n4);
    pix(8'd255, 8'd0, 8'd0, 1'b0, 1'b1, n5);
    idle(7);
    chk("oddline.beats", beats.size(), 5);
    chk("oddline.drops", drops.size(), 0);
    chk_beat("oddline.b0", 0, n2 + 3, 8'd16, 8'd128, 8'd128, 1'b0, 1'b1, 1'b0);
    chk_beat("oddline.b1", 1, n2 + 4, 8'd16, 8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    chk_beat("oddline.lone", 2, n3 + 4, 8'd16, 8'd128, 8'd128, 1'b0, 1'b0, 1'b1);
    chk_beat("oddline.next_even", 3, n5 + 3, 8'd82, 8'd90, 8'd90, 1'b0, 1'b1, 1'b0);
    chk_beat("oddline.next_odd", 4, n5 + 4, 8'd82, 8'd240, 8'd240, 1'b1, 1'b0, 1'b1);

    // Orphan: red even pixel followed by sol; red must never appear
    beats.delete();
    drops.delete();
    pix(8'd255, 8'd0, 8'd0, 1'b1, 1'b0, n0);
    pix(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, n1);
    pix(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, n2);
    idle(6);
    chk("orphan.drop_count", drops.size(), 1);
    if (drops.size() > 0) chk("orphan.drop_cycle", drops[0], n1 + 3);
    chk("orphan.beats", beats.size(), 2);
    chk_beat("orphan.even", 0, n2 + 3, 8'd16, 8'd128, 8'd128, 1'b0, 1'b1, 1'b0);
    chk_beat("orphan.odd", 1, n2 + 4, 8'd16, 8'd128, 8'd128, 1'b1, 1'b0, 1'b1);

    // Reset while a red even pixel is pending
    beats.delete();
    drops.delete();
    pix(8'd255, 8'd0, 8'd0, 1'b1, 1'b0, n0);
    idle(4);
    chk("midreset.no_early_beat", beats.size(), 0);
    do_reset("midreset");
    beats.delete();
    drops.delete();
    pix(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, m1);
    pix(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, m2);
    idle(6);
    chk("midreset.beats", beats.size(), 2);
    chk("midreset.drops", drops.size(), 0);
    chk_beat("midreset.even", 0, m2 + 3, 8'd16, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    chk_beat("midreset.odd", 1, m2 + 4, 8'd16, 8'd128, 8'd128, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb2ycbcr_422.md
# rgb2ycbcr_422

Pipelined RGB888 to BT.601 limited-range YCbCr converter with 4:4:4 to 4:2:2 chroma decimation. It sits on the output side of the video path and feeds the encoder or record interface with a 16-bit {Y, C} stream. It is the inverse of the capture-side YCbCr-to-RGB colour space converter. It has no backpressure: every valid input pixel produces exactly one output beat.

## Interface
- `CHROMA_AVG`, default 1: 1 = chroma is the rounded average of the even/odd pair; 0 = Cb is taken from the even pixel and Cr from the odd pixel.
- `clk` input 1: single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: pixel qualifier.
- `in_sol` input 1: start of line, qualified by `in_valid`.
- `in_eol` input 1: end of line, qualified by `in_valid`.
- `r`, `g`, `b` input 8 each: RGB888 pixel.
- `out_valid` output 1: output beat qualifier.
- `y_out` output 8: luma.
- `c_out` output 8: chroma sample.
- `c_is_cr` output 1: 0 = `c_out` is Cb, 1 = `c_out` is Cr.
- `out_sol`, `out_eol` output 1: line markers aligned to the output beat.
- `drop_err` output 1: one-cycle pulse when an unpaired pixel is discarded.

## Operation
- **Matrix:** all arithmetic is signed with ≥18-bit intermediates; `>>8` is an arithmetic shift (floor).
  - Y = 16 + ((66R + 129G + 25B + 128) >> 8)
  - Cb = 128 + ((−38R − 74G + 112B + 128) >> 8)
  - Cr = 128 + ((112R − 94G − 18B + 128) >> 8)
  - Results are always in the ranges Y 16..235 and C 16..240, so there is no clamp logic.
- **Pair phase:**
  - Phase is 0 (even) or 1 (odd). It is set to even by `in_sol` and toggles on every valid pixel.
  - An even pixel is held in a pending register: Y0, Cb0, Cr0, sol.
- **On an odd pixel (Y1, Cb1, Cr1):**
  - Emit the even beat: `y_out`=Y0, `c_out`=CbA, `c_is_cr`=0, `out_sol` = held sol.
  - On the next cycle, emit the odd beat: `y_out`=Y1, `c_out`=CrA, `c_is_cr`=1, `out_eol` = the odd pixel's eol.
  - With `CHROMA_AVG`=1: CbA = (Cb0 + Cb1 + 1) >> 1 and CrA = (Cr0 + Cr1 + 1) >> 1, using 9-bit sums.
  - With `CHROMA_AVG`=0: CbA = Cb0 and CrA = Cr1.
- **Even pixel with `in_eol` (odd-length line):** emit it alone in the odd-beat slot: `y_out`=Y0, `c_out`=Cb0, `c_is_cr`=0, `out_eol`=1.
- **`in_sol` while an even pixel is pending without eol:**
  - The pending pixel is discarded and never output.
  - `drop_err` pulses for 1 cycle.
  - The new pixel starts a new even phase.
- **`in_sol` and `in_eol` on the same pixel:** a one-pixel line, handled by the odd-length rule above.
- **Reset** (including mid-line) clears phase, the pending register and all pipeline valids. Nothing in flight is emitted after reset.

## Timing
- **Reset values:** every output is 0 in the cycle after `rst` is sampled high.
- **Pipeline:**
  - S1 registers the inputs.
  - S2 registers the products and Y/Cb/Cr.
  - S3 holds the pair/pending logic and the output registers.
- **Latency**, with N = the input cycle of the relevant pixel:
  - Odd pixel input at cycle N: even beat at N+3, odd beat at N+4.
  - Eol even pixel input at N: its beat at N+4.
  - `drop_err` for an `in_sol` input at N is asserted at N+3.
- **Throughput:** 1 pixel/clock sustained. Beats never collide, because an even pixel is only captured into the pending register, which frees the N+4 slot.
- **Gaps:** `in_valid` gaps of any length are allowed between or inside pairs. The pending pixel is held indefinitely.

## Structure
- **Shared package `csc_pkg`:**
  - Coefficient constants (66, 129, 25, −38, −74, 112, −94, −18).
  - Offsets 16/128 and the rounding constant 128.
  - Shared with the YCbCr-to-RGB block.
- **Sub-module `rgb2ycbcr_444`:** the 2-stage pipelined matrix (S1–S2), with a valid/sol/eol sideband. The top level adds the S3 pair logic.
- **Size:** about 200 lines of RTL total.

## Test plan
- **White:** two pixels (255,255,255) → beats at N+3/N+4: Y=235, C=128 (Cb), then Y=235, C=128 (Cr).
- **Red pair:** (255,0,0)×2 → Y=82, Cb=90, then Y=82, Cr=240.
- **Averaging:** red then black with `CHROMA_AVG`=1 → (Y=82, Cb=109), then (Y=16, Cr=184).
  - With `CHROMA_AVG`=0 → (82, 90), then (16, 128).
- **Odd-length line:** 3 black pixels, eol on the 3rd (input cycle N) → third beat at N+4 with Y=16, C=128, `c_is_cr`=0, `out_eol`=1.
  - A following line starts at even phase with `out_sol`=1 on its first beat.
- **Orphan:** even pixel, then `in_sol` without eol → `drop_err`=1 for exactly 1 cycle at N+3; the orphan never appears; the next pair is output normally.
- **Reset mid-pair:** assert `rst` while the pending register is full → all outputs 0 the next cycle and no stale beat afterwards.
  - After reset, the first pixel is treated as even.
